// File: rtl/traffic_conflict_monitor_pkg.sv
// Shared encodings for the traffic conflict monitor: approach/phase numbering,
// fault codes, FSM states and the lamp-decode result bundle.
package traffic_conflict_monitor_pkg;

  localparam int NUM_APPR = 4;

  // Approach / phase encoding (also the bit index in lamp vectors)
  localparam logic [1:0] PH_WN_ES = 2'd0;
  localparam logic [1:0] PH_NE_SW = 2'd1;
  localparam logic [1:0] PH_EW    = 2'd2;
  localparam logic [1:0] PH_NS    = 2'd3;

  // Fault codes; lower code has priority when several fire together
  localparam logic [2:0] FC_NONE         = 3'd0;
  localparam logic [2:0] FC_ILLEGAL_LAMP = 3'd1;
  localparam logic [2:0] FC_CONFLICT     = 3'd2;
  localparam logic [2:0] FC_NO_YELLOW    = 3'd3;
  localparam logic [2:0] FC_ORDER        = 3'd4;
  localparam logic [2:0] FC_STALL        = 3'd5;
  localparam logic [2:0] FC_MULTI_YELLOW = 3'd6;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_FAULTED = 2'd2
  } state_t;

  typedef struct packed {
    logic [NUM_APPR-1:0] green;
    logic [NUM_APPR-1:0] yellow;
    logic                illegal;
    logic [1:0]          phase;
  } lamp_dec_t;

  // True when two or more bits are set
  function automatic logic multi_hot(input logic [NUM_APPR-1:0] v);
    return (v & (v - NUM_APPR'(1))) != '0;
  endfunction

  // Lowest-numbered fault wins
  function automatic logic [2:0] first_fault(input logic [6:1] hit);
    first_fault = FC_NONE;
    for (int c = 6; c >= 1; c--)
      if (hit[c]) first_fault = 3'(c);
  endfunction

endpackage

// File: rtl/traffic_conflict_monitor_if.sv
// Lamp observation inputs and monitor status outputs.
// master = intersection side (drives lamps), slave = monitor.
interface traffic_conflict_monitor_if #(
  parameter int CNT_W = 8
);
  logic Green_WN_ES, Yellow_WN_ES, Red_WN_ES;
  logic Green_NE_SW, Yellow_NE_SW, Red_NE_SW;
  logic Green_EW,    Yellow_EW,    Red_EW;
  logic Green_NS,    Yellow_NS,    Red_NS;

  logic             FAULT;
  logic [2:0]       FAULT_CODE;
  logic [1:0]       PHASE;
  logic             PHASE_VALID;
  logic [CNT_W-1:0] ROTATIONS;

  modport master (
    output Green_WN_ES, Yellow_WN_ES, Red_WN_ES,
    output Green_NE_SW, Yellow_NE_SW, Red_NE_SW,
    output Green_EW,    Yellow_EW,    Red_EW,
    output Green_NS,    Yellow_NS,    Red_NS,
    input  FAULT, FAULT_CODE, PHASE, PHASE_VALID, ROTATIONS
  );

  modport slave (
    input  Green_WN_ES, Yellow_WN_ES, Red_WN_ES,
    input  Green_NE_SW, Yellow_NE_SW, Red_NE_SW,
    input  Green_EW,    Yellow_EW,    Red_EW,
    input  Green_NS,    Yellow_NS,    Red_NS,
    output FAULT, FAULT_CODE, PHASE, PHASE_VALID, ROTATIONS
  );
endinterface

// File: rtl/traffic_conflict_monitor_lamp_decode.sv
// Purely combinational lamp decode: green/yellow vectors, an illegal flag
// (some approach without exactly one lamp lit) and the encoded green phase.
module lamp_decode import traffic_conflict_monitor_pkg::*; (
  input  logic [NUM_APPR-1:0] green,
  input  logic [NUM_APPR-1:0] yellow,
  input  logic [NUM_APPR-1:0] red,
  output lamp_dec_t           dec
);

  logic [NUM_APPR-1:0] bad;

  // Exactly-one-of-three per approach: odd parity and not all three lit
  for (genvar a = 0; a < NUM_APPR; a++) begin : g_appr
    assign bad[a] = ~((green[a] ^ yellow[a] ^ red[a]) & ~(green[a] & yellow[a] & red[a]));
  end

  // Pack vectors and encode the lowest green approach (meaningful only when one is green)
  always_comb begin
    dec.green   = green;
    dec.yellow  = yellow;
    dec.illegal = |bad;
    dec.phase   = PH_WN_ES;
    for (int a = NUM_APPR - 1; a >= 0; a--)
      if (green[a]) dec.phase = 2'(a);
  end

endmodule

// File: rtl/traffic_conflict_monitor.sv
// Observes the intersection lamps every CLK edge, tracks the green phase
// rotation and latches the first safety fault until CLR.
module traffic_conflict_monitor import traffic_conflict_monitor_pkg::*; #(
  parameter int STALL_MAX = 4,
  parameter int CNT_W     = 8
)(
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        CLR,
  traffic_conflict_monitor_if.slave   bus
);

  // Stall counter holds up to STALL_MAX+1 so the overflow sample is representable
  localparam int            SW        = $clog2(STALL_MAX + 2);
  localparam logic [SW-1:0] STALL_LIM = SW'(STALL_MAX);

  state_t              state_q, state_d;
  logic                fault_q;
  logic [2:0]          code_q;
  logic [1:0]          phase_q;
  logic                pvalid_q;
  logic [CNT_W-1:0]    rot_q;
  logic [SW-1:0]       stall_q, stall_inc;
  logic [NUM_APPR-1:0] prev_y_q, prev_g_q;

  lamp_dec_t           dec;
  logic                one_green, change, fault_any, rotate;
  logic [6:1]          hit;
  logic [2:0]          fcode;

  lamp_decode u_dec (
    .green  ({bus.Green_NS,  bus.Green_EW,  bus.Green_NE_SW,  bus.Green_WN_ES}),
    .yellow ({bus.Yellow_NS, bus.Yellow_EW, bus.Yellow_NE_SW, bus.Yellow_WN_ES}),
    .red    ({bus.Red_NS,    bus.Red_EW,    bus.Red_NE_SW,    bus.Red_WN_ES}),
    .dec    (dec)
  );

  // Per-sample checks against the previous sample and current phase
  always_comb begin
    one_green = (dec.green != '0) && !multi_hot(dec.green);
    change    = one_green && (dec.phase != phase_q);
    stall_inc = (stall_q > STALL_LIM) ? stall_q : stall_q + SW'(1);
    hit       = '0;
    hit[FC_ILLEGAL_LAMP] = dec.illegal;
    hit[FC_CONFLICT]     = multi_hot(dec.green);
    hit[FC_NO_YELLOW]    = |(dec.green & ~prev_y_q & ~prev_g_q);
    hit[FC_ORDER]        = (state_q == ST_RUN) && change && (dec.phase != phase_q + 2'd1);
    hit[FC_STALL]        = (state_q == ST_RUN) && !change && (stall_inc > STALL_LIM);
    hit[FC_MULTI_YELLOW] = multi_hot(dec.yellow);
    fault_any = |hit;
    fcode     = first_fault(hit);
    rotate    = (state_q == ST_RUN) && change && !fault_any &&
                (phase_q == PH_NS) && (dec.phase == PH_WN_ES);
  end

  // FSM state register
  always_ff @(posedge CLK) begin
    if (RST) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // FSM next state; CLR returns to IDLE from anywhere
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (fault_any) state_d = ST_FAULTED;
                  else if (one_green) state_d = ST_RUN;
      ST_RUN:     if (fault_any) state_d = ST_FAULTED;
      ST_FAULTED: state_d = ST_FAULTED;
      default:    state_d = ST_IDLE;
    endcase
    if (CLR) state_d = ST_IDLE;
  end

  // Registered status, history and counters; everything holds while FAULTED
  always_ff @(posedge CLK) begin
    if (RST) begin
      fault_q  <= 1'b0;
      code_q   <= FC_NONE;
      phase_q  <= PH_WN_ES;
      pvalid_q <= 1'b0;
      rot_q    <= '0;
      stall_q  <= '0;
      prev_y_q <= '0;
      prev_g_q <= '0;
    end else if (CLR) begin
      fault_q  <= 1'b0;
      code_q   <= FC_NONE;
      phase_q  <= PH_WN_ES;
      pvalid_q <= 1'b0;
      stall_q  <= '0;
      prev_y_q <= '0;
      prev_g_q <= '0;
    end else if (state_q != ST_FAULTED) begin
      prev_y_q <= dec.yellow;
      prev_g_q <= dec.green;
      pvalid_q <= one_green;
      if (one_green) phase_q <= dec.phase;
      if (fault_any) begin
        fault_q <= 1'b1;
        code_q  <= fcode;
      end
      // IDLE keeps the counter at zero so entry to RUN starts fresh
      if (state_q == ST_RUN) stall_q <= change ? '0 : stall_inc;
      else                   stall_q <= '0;
      if (rotate) rot_q <= rot_q + CNT_W'(1);
    end
  end

  assign bus.FAULT       = fault_q;
  assign bus.FAULT_CODE  = code_q;
  assign bus.PHASE       = phase_q;
  assign bus.PHASE_VALID = pvalid_q;
  assign bus.ROTATIONS   = rot_q;

endmodule

// File: tb/tb_traffic_conflict_monitor.sv
// Directed scenarios plus randomized lamp sequences checked every cycle
// against a sample-by-sample reference model of the monitoring rules.
module tb_traffic_conflict_monitor;
  localparam int STALL_MAX = 4;
  localparam int CNT_W     = 8;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic CLR = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  traffic_conflict_monitor_if #(.CNT_W(CNT_W)) bus ();

  traffic_conflict_monitor #(.STALL_MAX(STALL_MAX), .CNT_W(CNT_W)) dut (
    .CLK (CLK),
    .RST (RST),
    .CLR (CLR),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  bit [3:0] dg, dy, dr;

  // reference model: mode 0 idle, 1 run, 2 faulted
  int       m_mode  = 0;
  bit       m_fault = 0;
  int       m_code  = 0;
  int       m_phase = 0;
  bit       m_pv    = 0;
  int       m_rot   = 0;
  int       m_stall = 0;
  bit [3:0] m_py    = '0;
  bit [3:0] m_pg    = '0;

  function automatic bit [3:0] onehot(input int p);
    bit [3:0] v;
    v = '0;
    v[p] = 1'b1;
    return v;
  endfunction

  task automatic drive(input bit [3:0] g, input bit [3:0] y, input bit [3:0] r,
                       input bit clr, input bit rst);
    dg = g; dy = y; dr = r; CLR = clr; RST = rst;
    bus.Green_WN_ES = g[0]; bus.Yellow_WN_ES = y[0]; bus.Red_WN_ES = r[0];
    bus.Green_NE_SW = g[1]; bus.Yellow_NE_SW = y[1]; bus.Red_NE_SW = r[1];
    bus.Green_EW    = g[2]; bus.Yellow_EW    = y[2]; bus.Red_EW    = r[2];
    bus.Green_NS    = g[3]; bus.Yellow_NS    = y[3]; bus.Red_NS    = r[3];
  endtask

  task automatic legal(input bit [3:0] g, input bit [3:0] y);
    drive(g, y, ~(g | y), 1'b0, 1'b0);
  endtask

  task automatic ref_update();
    int ng, ny, cur, code, nxt_stall;
    bit ill, chg;
    if (RST) begin
      m_mode = 0; m_fault = 0; m_code = 0; m_phase = 0; m_pv = 0;
      m_rot = 0; m_stall = 0; m_py = '0; m_pg = '0;
      return;
    end
    if (CLR) begin
      m_mode = 0; m_fault = 0; m_code = 0; m_phase = 0; m_pv = 0;
      m_stall = 0; m_py = '0; m_pg = '0;
      return;
    end
    if (m_mode == 2) return;
    ng  = $countones(dg);
    ny  = $countones(dy);
    ill = 0;
    cur = -1;
    for (int a = 0; a < 4; a++) begin
      if (int'(dg[a]) + int'(dy[a]) + int'(dr[a]) != 1) ill = 1;
      if (dg[a]) cur = a;
    end
    chg = (ng == 1) && (cur != m_phase);
    code = 0;
    if (ill)                                                     code = 1;
    else if (ng > 1)                                             code = 2;
    else if ((dg & ~m_py & ~m_pg) != 4'b0)                       code = 3;
    else if (m_mode == 1 && chg && cur != (m_phase + 1) % 4)     code = 4;
    else if (m_mode == 1 && !chg && m_stall + 1 > STALL_MAX)     code = 5;
    else if (ny > 1)                                             code = 6;
    if (code == 0 && m_mode == 1 && chg && m_phase == 3 && cur == 0)
      m_rot = (m_rot + 1) % (1 << CNT_W);
    nxt_stall = (m_stall + 1 > STALL_MAX + 1) ? STALL_MAX + 1 : m_stall + 1;
    m_stall = (m_mode == 1) ? (chg ? 0 : nxt_stall) : 0;
    m_pv = (ng == 1);
    if (ng == 1) m_phase = cur;
    m_py = dy;
    m_pg = dg;
    if (code != 0) begin
      m_fault = 1; m_code = code; m_mode = 2;
    end else if (m_mode == 0 && ng == 1) begin
      m_mode = 1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // One clock: model advances on the same edge, outputs sampled 1 unit later
  task automatic step(input string tag);
    @(posedge CLK);
    ref_update();
    #1;
    check({tag, " FAULT"},       32'(bus.FAULT),       32'(m_fault));
    check({tag, " FAULT_CODE"},  32'(bus.FAULT_CODE),  32'(m_code));
    check({tag, " PHASE"},       32'(bus.PHASE),       32'(m_phase));
    check({tag, " PHASE_VALID"}, 32'(bus.PHASE_VALID), 32'(m_pv));
    check({tag, " ROTATIONS"},   32'(bus.ROTATIONS),   32'(m_rot));
  endtask

  task automatic expect5(input string tag, input int f, input int c, input int ph,
                         input int pv, input int rot);
    check({tag, " FAULT"},       32'(bus.FAULT),       32'(f));
    check({tag, " FAULT_CODE"},  32'(bus.FAULT_CODE),  32'(c));
    check({tag, " PHASE"},       32'(bus.PHASE),       32'(ph));
    check({tag, " PHASE_VALID"}, 32'(bus.PHASE_VALID), 32'(pv));
    check({tag, " ROTATIONS"},   32'(bus.ROTATIONS),   32'(rot));
  endtask

  initial begin
    int       gp, nxt, hold;
    bit       lead, clr, rst;
    bit [3:0] g, y, r;

    // reset state
    drive(4'h0, 4'h0, 4'hF, 1'b0, 1'b1);
    step("reset");
    expect5("reset", 0, 0, 0, 0, 0);

    // legal rotation: two lead-in samples, then 0..3 three times
    legal(4'b0000, 4'b0001); step("lead");
    step("lead");
    for (int rep = 0; rep < 3; rep++)
      for (int p = 0; p < 4; p++) begin
        legal(onehot(p), onehot((p + 1) % 4));
        step("legal");
        check("legal PHASE", 32'(bus.PHASE), 32'(p));
        check("legal FAULT", 32'(bus.FAULT), 0);
      end
    check("legal ROTATIONS", 32'(bus.ROTATIONS), 2);
    legal(4'b0001, 4'b0010); step("rot3");
    expect5("rot3", 0, 0, 0, 1, 3);

    // EW and NS green together, then frozen outputs
    drive(4'b1100, 4'b0000, 4'b0011, 1'b0, 1'b0); step("conflict");
    expect5("conflict", 1, 2, 0, 0, 3);
    legal(4'b0010, 4'b0100); step("frozen");
    expect5("frozen1", 1, 2, 0, 0, 3);
    drive(4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0); step("frozen");
    expect5("frozen2", 1, 2, 0, 0, 3);

    // CLR with a conflicting sample on the same edge: CLR wins, rotations kept
    drive(4'b1100, 4'b0000, 4'b0011, 1'b1, 1'b0); step("clr");
    expect5("clr", 0, 0, 0, 0, 3);

    // green without a preceding yellow
    legal(4'b0000, 4'b0001); step("ny_lead");
    legal(4'b0001, 4'b0010); step("ny_run");
    expect5("ny_run", 0, 0, 0, 1, 3);
    legal(4'b0100, 4'b0000); step("no_yellow");
    expect5("no_yellow", 1, 3, 2, 1, 3);
    drive(4'b0000, 4'b0000, 4'b1111, 1'b1, 1'b0); step("clr2");

    // out-of-order phase with a proper yellow
    legal(4'b0000, 4'b0001); step("ord_lead");
    legal(4'b0001, 4'b0100); step("ord_run");
    legal(4'b0100, 4'b0000); step("order");
    expect5("order", 1, 4, 2, 1, 3);
    drive(4'b0000, 4'b0000, 4'b1111, 1'b1, 1'b0); step("clr3");

    // NE_SW green held: fault on the 5th sample without a change
    legal(4'b0000, 4'b0010); step("stall_lead");
    for (int i = 1; i <= 6; i++) begin
      legal(4'b0010, 4'b0000);
      step("stall");
      if (i < 6) check("stall_pre FAULT", 32'(bus.FAULT), 0);
    end
    expect5("stall", 1, 5, 1, 1, 3);
    drive(4'b0000, 4'b0000, 4'b1111, 1'b1, 1'b0); step("clr4");

    // NS green+red with EW green: illegal lamp beats conflict
    drive(4'b1100, 4'b0000, 4'b1011, 1'b0, 1'b0); step("illegal");
    expect5("illegal", 1, 1, 0, 0, 3);

    // RST and CLR together with a faulty sample while FAULTED
    drive(4'b1100, 4'b0000, 4'b0011, 1'b1, 1'b1); step("rst_clr");
    expect5("rst_clr", 0, 0, 0, 0, 0);

    // 256 completed cycles wrap the 8-bit counter
    legal(4'b0000, 4'b0001); step("wrap_lead");
    for (int k = 0; k < 257; k++)
      for (int p = 0; p < 4; p++) begin
        legal(onehot(p), onehot((p + 1) % 4));
        step("wrap");
      end
    expect5("wrap", 0, 0, 3, 1, 0);

    // randomized: mostly legal rotation with random holds, skips, garbage, CLR, RST
    gp = 0; nxt = 1; hold = 3; lead = 1;
    for (int i = 0; i < 700; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      clr = !rst && ($urandom_range(0, (m_mode == 2) ? 3 : 59) == 0);
      if (lead) begin
        g = 4'b0000; y = onehot(gp); r = ~y; lead = 0;
      end else if ($urandom_range(0, 99) < 5) begin
        g = 4'($urandom); y = 4'($urandom); r = 4'($urandom);
      end else begin
        g = onehot(gp); y = onehot(nxt); r = ~(g | y);
        hold--;
        if (hold == 0) begin
          gp   = nxt;
          nxt  = (gp + (($urandom_range(0, 9) == 0) ? 2 : 1)) % 4;
          hold = $urandom_range(1, STALL_MAX + 2);
        end
      end
      drive(g, y, r, clr, rst);
      step("rand");
      if (clr || rst) lead = 1;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/traffic_conflict_monitor.md
TRAFFIC_CONFLICT_MONITOR -- requirements
Module: traffic_conflict_monitor

Interface
REQ-001 SHALL have parameter STALL_MAX, default 4: maximum consecutive samples without a green-phase change while in RUN.
REQ-002 SHALL have parameter CNT_W, default 8: width of ROTATIONS.
REQ-003 SHALL have port CLK  in  1  clock; all inputs are sampled on its rising edge.
REQ-004 SHALL have port RST  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port CLR  in  1  synchronous fault clear.
REQ-006 SHALL have ports Green_/Yellow_/Red_ WN_ES, NE_SW, EW and NS  in  1 each  (12 ports) lamp drives observed from the intersection controller.
REQ-007 SHALL have port FAULT  out  1  sticky fault flag.
REQ-008 SHALL have port FAULT_CODE  out  3  first fault detected; 0 = none.
REQ-009 SHALL have port PHASE  out  2  currently green approach: 0 WN_ES, 1 NE_SW, 2 EW, 3 NS.
REQ-010 SHALL have port PHASE_VALID  out  1  PHASE is meaningful (exactly one approach green).
REQ-011 SHALL have port ROTATIONS  out  CNT_W  count of completed cycles.

Function
REQ-012 All outputs SHALL be registered, with one-edge latency: a violation in the sample at edge k is visible on the outputs immediately after edge k.
REQ-013 SHALL implement FSM states IDLE, RUN and FAULTED.
- IDLE -> RUN on the first fault-free sample with one approach green.
- IDLE/RUN -> FAULTED on any fault.
- Any state -> IDLE on CLR.
REQ-014 SHALL apply fault codes as follows; simultaneous faults record the lowest code.
- 1 ILLEGAL_LAMP: any approach without exactly one lamp lit.
- 2 CONFLICT: more than one approach green.
- 3 NO_YELLOW: an approach green now that was neither yellow nor green in the previous sample.
- 4 ORDER (RUN only): the new green phase is not (previous phase + 1) mod 4.
- 5 STALL (RUN only): stall counter exceeds STALL_MAX.
- 6 MULTI_YELLOW: more than one approach yellow.
REQ-015 In FAULTED, all checks SHALL be suspended, and FAULT, FAULT_CODE, PHASE and ROTATIONS SHALL be frozen.
REQ-016 The stall counter SHALL reset to 0 on a green-phase change or on entry to RUN, and SHALL otherwise increment each RUN sample.
- STALL fires on the (STALL_MAX+1)th sample without a change.
- The counter saturates; it does not wrap.
REQ-017 ROTATIONS SHALL increment when the phase changes from 3 to 0 in RUN, wrapping modulo 2^CNT_W.
REQ-018 The previous-yellow and previous-green vectors SHALL update every sample outside FAULTED.
REQ-019 CLR SHALL clear FAULT, FAULT_CODE, PHASE, PHASE_VALID, the stall counter and the previous-lamp vectors, and SHALL retain ROTATIONS.
- CLR wins over a fault detected on the same edge.
REQ-020 A sample with no green SHALL drive PHASE_VALID=0 and leave PHASE holding its last value.

Reset
REQ-021 RST SHALL force the FSM to IDLE and set FAULT=0, FAULT_CODE=0, PHASE=0, PHASE_VALID=0, ROTATIONS=0, stall counter=0 and previous-lamp vectors=0.
REQ-022 RST SHALL take priority over CLR and over any fault on the same edge, including mid-RUN and in FAULTED.

Structure
REQ-023 A shared package SHALL hold the phase encoding constants (WN_ES..NS), fault code constants (1-6) and FSM state constants.
REQ-024 A sub-module lamp_decode SHALL convert the 12 lamps into a green vector [3:0], a yellow vector [3:0], an illegal flag and an encoded phase; it SHALL be purely combinational.

Verification
REQ-025 Legal sequence: RST, then 2 samples of WN_ES yellow / others red, then phases 0,1,2,3 repeated 3 times, each with the next approach yellow -> FAULT=0, PHASE sequence 0,1,2,3, ROTATIONS=2.
REQ-026 EW and NS green in the same sample -> FAULT=1, FAULT_CODE=2 after that edge; outputs frozen on the following samples.
REQ-027 WN_ES green with NE_SW yellow, then EW green -> FAULT_CODE=3; WN_ES green with EW yellow, then EW green -> FAULT_CODE=4.
REQ-028 STALL_MAX=4, NE_SW green held 6 samples in RUN -> FAULT_CODE=5 after the 5th sample without a change.
REQ-029 NS green and red lit together while EW is also green -> FAULT_CODE=1, as lowest code wins.
REQ-030 In FAULTED with ROTATIONS=3:
- CLR -> FAULT=0, FAULT_CODE=0, PHASE_VALID=0, ROTATIONS=3.
- RST and CLR together -> ROTATIONS=0.
